register_file: RTL and testbench

//  - ARM-style architectural register file: 16 x 32-bit, R0..R14 stored, R15 = PC value supplied externally.
//  - Two combinational read ports (RD1, RD2), one synchronous write port (WD3 at RA3).
//  - Sits in the processor datapath between decode (RA1/RA2/RA3) and ALU operand/writeback muxes.

---
 rtl/register_file_if.sv | 25 ++
 rtl/register_file.sv | 54 +++++
 tb/tb_register_file.sv | 122 ++++++++++++
 3 files changed

// File: rtl/register_file_if.sv
// Bus bundle for the architectural register file: decode-side addresses,
// writeback data, the externally supplied PC (R15) and the two read results.
interface register_file_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
);
   logic [ADDR_W-1:0] RA1;
   logic [ADDR_W-1:0] RA2;
   logic [ADDR_W-1:0] RA3;
   logic [DATA_W-1:0] WD3;
   logic [DATA_W-1:0] R15;
   logic              WE3;
   logic [DATA_W-1:0] RD1;
   logic [DATA_W-1:0] RD2;

   modport master (
      output RA1, RA2, RA3, WD3, R15, WE3,
      input  RD1, RD2
   );

   modport slave (
      input  RA1, RA2, RA3, WD3, R15, WE3,
      output RD1, RD2
   );
endinterface

// File: rtl/register_file.sv
// ARM-style 16 x 32 register file: R0..R14 stored, PC_IDX reads the external PC.
// Define REGFILE_BYPASS_EN for write-first forwarding from WD3 to the read ports.
module register_file #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4,
   parameter int PC_IDX = 15
) (
   input  logic            clk,
   input  logic            rst,
   register_file_if.slave  bus
);

   logic [DATA_W-1:0] r_regs [PC_IDX];
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_wr_valid;

   // The PC slot has no storage, so a write addressed to it is simply dropped.
   assign w_wr_valid = bus.WE3 && (bus.RA3 != ADDR_W'(PC_IDX));

   // NOTE: the whole array is cleared by the async reset because software may read
   // any register straight after reset; sequential state uses <= only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PC_IDX; i++) r_regs[i] <= '0;
      end else if (w_wr_valid) begin
         for (int i = 0; i < PC_IDX; i++) begin
            if (bus.RA3 == ADDR_W'(i)) r_regs[i] <= bus.WD3;
         end
      end
   end

   // NOTE: both outputs get a default first so the read muxes never infer latches.
   always_comb begin
      w_rd1 = '0;
      w_rd2 = '0;
      for (int i = 0; i < PC_IDX; i++) begin
         if (bus.RA1 == ADDR_W'(i)) w_rd1 = r_regs[i];
         if (bus.RA2 == ADDR_W'(i)) w_rd2 = r_regs[i];
      end
      if (bus.RA1 == ADDR_W'(PC_IDX)) w_rd1 = bus.R15;
      if (bus.RA2 == ADDR_W'(PC_IDX)) w_rd2 = bus.R15;
`ifdef REGFILE_BYPASS_EN
      // Forward writeback data so a dependent read sees it in the same cycle.
      if (rst && w_wr_valid && (bus.RA1 == bus.RA3)) w_rd1 = bus.WD3;
      if (rst && w_wr_valid && (bus.RA2 == bus.RA3)) w_rd2 = bus.WD3;
`else
`endif
   end

   assign bus.RD1 = w_rd1;
   assign bus.RD2 = w_rd2;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: stimulus queues expected read data,
// a negedge monitor pops and compares it against RD1/RD2.
module tb_register_file;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 4;

   typedef struct {
      string             name;
      logic [DATA_W-1:0] e1;
      logic [DATA_W-1:0] e2;
   } exp_t;

   logic clk;
   logic rst;
   exp_t q_exp [$];
   int   n_checks = 0;
   int   n_errors = 0;

   register_file_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   register_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PC_IDX(15)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: reads are combinational, so every queued expectation is due at the
   // negedge following the cycle in which its inputs were driven.
   always @(negedge clk) begin
      while (q_exp.size() > 0) begin
         exp_t e;
         e = q_exp.pop_front();
         check({e.name, ".RD1"}, bus.RD1, e.e1);
         check({e.name, ".RD2"}, bus.RD2, e.e2);
      end
   end

   task automatic vec(input string name, input logic rst_v,
                      input logic [3:0] ra1, input logic [3:0] ra2,
                      input logic [3:0] ra3, input logic [31:0] wd3,
                      input logic we3, input logic [31:0] r15,
                      input logic [31:0] e1, input logic [31:0] e2);
      exp_t e;
      @(posedge clk);
      #1;
      rst     = rst_v;
      bus.RA1 = ra1;
      bus.RA2 = ra2;
      bus.RA3 = ra3;
      bus.WD3 = wd3;
      bus.WE3 = we3;
      bus.R15 = r15;
      e.name = name;
      e.e1   = e1;
      e.e2   = e2;
      q_exp.push_back(e);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] b_w10, b_w3a, b_w3b, b_w0, b_w14;
`ifdef REGFILE_BYPASS_EN
      b_w10 = 32'h13650;  b_w3a = 32'hA5;  b_w3b = 32'hA5;
      b_w0  = 32'hFFFF_FFFF;  b_w14 = 32'h77;
`else
      b_w10 = 32'h0;  b_w3a = 32'h0;  b_w3b = 32'h0;
      b_w0  = 32'h0;  b_w14 = 32'h0;
`endif
      rst     = 1'b0;
      bus.RA1 = '0;
      bus.RA2 = '0;
      bus.RA3 = '0;
      bus.WD3 = '0;
      bus.WE3 = 1'b0;
      bus.R15 = '0;

      //   name        rst  RA1    RA2    RA3    WD3              WE3   R15         RD1 exp          RD2 exp
      vec("rst_rd01",  0, 4'd0,  4'd1,  4'd0,  32'h0,           0, 32'h100,  32'h0,           32'h0);
      vec("rst_pc",    0, 4'd15, 4'd0,  4'd2,  32'h55,          1, 32'h100,  32'h100,         32'h0);
      vec("rst_nowr",  0, 4'd2,  4'd15, 4'd0,  32'h0,           0, 32'h100,  32'h0,           32'h100);
      vec("wr10_pre",  1, 4'd10, 4'd10, 4'd10, 32'h13650,       1, 32'h100,  b_w10,           b_w10);
      vec("wr10_post", 1, 4'd10, 4'd0,  4'd10, 32'hDEAD,        0, 32'h100,  32'h13650,       32'h0);
      vec("we0_hold",  1, 4'd10, 4'd11, 4'd10, 32'hDEAD,        0, 32'h100,  32'h13650,       32'h0);
      vec("pc_write",  1, 4'd15, 4'd10, 4'd15, 32'hFFFF,        1, 32'h8,    32'h8,           32'h13650);
      vec("pc_after",  1, 4'd15, 4'd14, 4'd0,  32'h0,           0, 32'h8,    32'h8,           32'h0);
      vec("pc_both",   1, 4'd15, 4'd15, 4'd0,  32'h0,           0, 32'h1234, 32'h1234,        32'h1234);
      vec("wr3_pre",   1, 4'd3,  4'd3,  4'd3,  32'hA5,          1, 32'h8,    b_w3a,           b_w3b);
      vec("wr3_post",  1, 4'd3,  4'd10, 4'd0,  32'h0,           0, 32'h8,    32'hA5,          32'h13650);
      vec("wr0_pre",   1, 4'd0,  4'd14, 4'd0,  32'hFFFF_FFFF,   1, 32'h8,    b_w0,            32'h0);
      vec("wr14_pre",  1, 4'd0,  4'd14, 4'd14, 32'h77,          1, 32'h8,    32'hFFFF_FFFF,   b_w14);
      vec("edge_regs", 1, 4'd14, 4'd0,  4'd0,  32'h0,           0, 32'h8,    32'h77,          32'hFFFF_FFFF);
      vec("async_rst", 0, 4'd10, 4'd3,  4'd10, 32'h999,         1, 32'h8,    32'h0,           32'h0);
      vec("rst_held",  0, 4'd10, 4'd14, 4'd0,  32'h0,           0, 32'h8,    32'h0,           32'h0);
      vec("rel_rst",   1, 4'd0,  4'd15, 4'd0,  32'h0,           0, 32'h200,  32'h0,           32'h200);
      vec("rel_wr",    1, 4'd10, 4'd3,  4'd0,  32'h0,           0, 32'h200,  32'h0,           32'h0);

      for (int i = 0; i < 4 && q_exp.size() > 0; i++) @(posedge clk);
      check("drain_q", 32'(q_exp.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
